// File: rtl/emissor_pkg.sv
// Shared types and default constants for the elevator request issuer.
// States, the origin/destination pair layout and the default parameter values.
package emissor_pkg;

   localparam int N_ANDARES_PAD   = 16;
   localparam int PROFUNDIDADE_PAD = 4;
   localparam int T_PRONTO_PAD    = 2;
   localparam int T_INTERVALO_PAD = 4;

   typedef struct packed {
      logic [3:0] origem;
      logic [3:0] destino;
   } par_t;

   typedef enum logic [1:0] {
      OCIOSO      = 2'd0,
      CARREGA     = 2'd1,
      PRONTO_ALTO = 2'd2,
      INTERVALO   = 2'd3
   } estado_t;

endpackage

// File: rtl/fila_pedidos.sv
// Synchronous FIFO of origin/destination pairs with occupancy, full and empty.
// Callers must not push when full without popping, nor pop when empty.
module fila_pedidos
   import emissor_pkg::*;
#(
   parameter int PROFUNDIDADE = PROFUNDIDADE_PAD
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              push,
   input  logic                              pop,
   input  par_t                              entrada,
   output par_t                              cabeca,
   output logic                              vazio,
   output logic                              cheio,
   output logic [$clog2(PROFUNDIDADE+1)-1:0] n_pendentes
);

   localparam int W_P = $clog2(PROFUNDIDADE);
   localparam int W_N = $clog2(PROFUNDIDADE + 1);

   par_t           mem [PROFUNDIDADE];
   logic [W_P-1:0] cauda;
   logic [W_P-1:0] topo;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[cauda] <= entrada;
      end
   end

   // Pointers wrap by width; the counter alone tells full from empty.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cauda       <= '0;
         topo        <= '0;
         n_pendentes <= '0;
      end else begin
         if (push) begin
            cauda <= cauda + 1'b1;
         end
         if (pop) begin
            topo <= topo + 1'b1;
         end
         case ({push, pop})
            2'b10:   n_pendentes <= n_pendentes + 1'b1;
            2'b01:   n_pendentes <= n_pendentes - 1'b1;
            default: n_pendentes <= n_pendentes;
         endcase
      end
   end

   assign cabeca = mem[topo];
   assign vazio  = (n_pendentes == '0);
   assign cheio  = (n_pendentes == W_N'(PROFUNDIDADE));

endmodule

// File: rtl/emissor_pedidos.sv
// Request issuer: queues origin/destination calls and presents them with a timed pronto pulse.
// Optional EMISSOR_VALIDA_EN rejects same-floor or out-of-range requests.
module emissor_pedidos
   import emissor_pkg::*;
#(
   parameter int N_ANDARES    = N_ANDARES_PAD,
   parameter int PROFUNDIDADE = PROFUNDIDADE_PAD,
   parameter int T_PRONTO     = T_PRONTO_PAD,
   parameter int T_INTERVALO  = T_INTERVALO_PAD
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              pedido,
   input  logic [3:0]                        origem_in,
   input  logic [3:0]                        destino_in,
   input  logic                              ocupado,
   output logic [3:0]                        origem,
   output logic [3:0]                        destino,
   output logic                              pronto,
   output logic                              vazio,
   output logic                              cheio,
   output logic [$clog2(PROFUNDIDADE+1)-1:0] n_pendentes,
   output logic                              descartado
);

   localparam int T_MAX = (T_PRONTO > T_INTERVALO) ? T_PRONTO : T_INTERVALO;
   localparam int W_C   = $clog2(T_MAX + 1);
   localparam logic [W_C-1:0] C_PRONTO    = W_C'(T_PRONTO - 1);
   localparam logic [W_C-1:0] C_INTERVALO = W_C'(T_INTERVALO - 1);
   localparam logic [4:0]     N_LIM       = 5'(N_ANDARES);

   estado_t        estado;
   logic [W_C-1:0] contador;
   logic           valido;
   logic           pop;
   logic           aceita;
   par_t           entrada;
   par_t           cabeca;

`ifdef EMISSOR_VALIDA_EN
   assign valido = (origem_in != destino_in) &&
                   ({1'b0, origem_in} < N_LIM) &&
                   ({1'b0, destino_in} < N_LIM);
`else
   logic unused_n_andares;
   assign valido           = 1'b1;
   assign unused_n_andares = ^N_LIM;
`endif

   // The pop is taken on the edge entering CARREGA so data leads pronto by a full cycle.
   assign pop     = (estado == OCIOSO) && !vazio && !ocupado;
   assign aceita  = pedido && valido && (!cheio || pop);
   assign entrada = {origem_in, destino_in};

   fila_pedidos #(
      .PROFUNDIDADE(PROFUNDIDADE)
   ) u_fila (
      .clock      (clock),
      .reset      (reset),
      .push       (aceita),
      .pop        (pop),
      .entrada    (entrada),
      .cabeca     (cabeca),
      .vazio      (vazio),
      .cheio      (cheio),
      .n_pendentes(n_pendentes)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= OCIOSO;
         contador   <= '0;
         origem     <= '0;
         destino    <= '0;
         pronto     <= 1'b0;
         descartado <= 1'b0;
      end else begin
         descartado <= pedido && !aceita;
         case (estado)
            OCIOSO: begin
               if (pop) begin
                  estado  <= CARREGA;
                  origem  <= cabeca.origem;
                  destino <= cabeca.destino;
               end
            end
            CARREGA: begin
               estado   <= PRONTO_ALTO;
               pronto   <= 1'b1;
               contador <= C_PRONTO;
            end
            PRONTO_ALTO: begin
               if (contador == '0) begin
                  estado   <= INTERVALO;
                  pronto   <= 1'b0;
                  contador <= C_INTERVALO;
               end else begin
                  contador <= contador - 1'b1;
               end
            end
            INTERVALO: begin
               if (contador == '0) begin
                  estado <= OCIOSO;
               end else begin
                  contador <= contador - 1'b1;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_emissor_pedidos.sv
// Self-checking bench for emissor_pedidos: table-driven single request, directed corner
// sequences and random traffic, all checked every cycle against a queue-based model.
module tb_emissor_pedidos;

   localparam int N_AND = 10;
   localparam int PROF  = 4;
   localparam int TP    = 2;
   localparam int TI    = 4;
   localparam int NW    = $clog2(PROF + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          pedido = 1'b0;
   logic          ocupado = 1'b0;
   logic [3:0]    origem_in = '0;
   logic [3:0]    destino_in = '0;
   logic [3:0]    origem;
   logic [3:0]    destino;
   logic          pronto;
   logic          vazio;
   logic          cheio;
   logic [NW-1:0] n_pendentes;
   logic          descartado;

   always #5 clock = ~clock;

   emissor_pedidos #(
      .N_ANDARES   (N_AND),
      .PROFUNDIDADE(PROF),
      .T_PRONTO    (TP),
      .T_INTERVALO (TI)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pedido     (pedido),
      .origem_in  (origem_in),
      .destino_in (destino_in),
      .ocupado    (ocupado),
      .origem     (origem),
      .destino    (destino),
      .pronto     (pronto),
      .vazio      (vazio),
      .cheio      (cheio),
      .n_pendentes(n_pendentes),
      .descartado (descartado)
   );

   int checks = 0;
   int passes = 0;

   // Model: a queue of pending pairs plus the edge index from which the next pop may occur.
   logic [7:0] fila_m[$];
   int         k = 0;
   int         livre = 0;
   int         inicio = -100;
   logic [3:0] m_org = '0;
   logic [3:0] m_dst = '0;
   logic       m_desc = 1'b0;
   logic       m_pronto = 1'b0;

   logic [7:0] entregues[$];
   int         tempos[$];
   logic       pronto_ant = 1'b0;
   logic       cheio_visto = 1'b0;
   logic       pronto_visto = 1'b0;
   int         desc_cont = 0;

   typedef struct {
      logic          ped;
      logic [3:0]    o;
      logic [3:0]    d;
      logic          oc;
      logic          pr;
      logic [3:0]    org;
      logic [3:0]    dst;
      logic          vz;
      logic [NW-1:0] n;
   } vetor_t;

   vetor_t     tabela[11];
   logic [7:0] par_esp[4];

   function automatic bit valida(input logic [3:0] o, input logic [3:0] d);
`ifdef EMISSOR_VALIDA_EN
      return (o != d) && (int'(o) < N_AND) && (int'(d) < N_AND);
`else
      return 1'b1;
`endif
   endfunction

   task automatic checkOutput(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
      checks++;
      if (real_v === esperado) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", nome, k, real_v, esperado);
      end
   endtask

   task automatic applyStimulus(input logic p, input logic [3:0] o, input logic [3:0] d, input logic oc);
      bit   pode_pop;
      bit   aceita;
      logic [14:0] real_v;
      logic [14:0] esp_v;
      pedido     = p;
      origem_in  = o;
      destino_in = d;
      ocupado    = oc;
      @(posedge clock);
      pode_pop = (k >= livre) && (fila_m.size() > 0) && !oc;
      if (pode_pop) begin
         {m_org, m_dst} = fila_m.pop_front();
         inicio = k + 1;
         livre  = k + TP + TI + 2;
      end
      aceita = p && valida(o, d) && (fila_m.size() < PROF);
      if (aceita) begin
         fila_m.push_back({o, d});
      end
      m_desc   = p && !aceita;
      m_pronto = (k >= inicio) && (k < inicio + TP);
      k++;
      @(negedge clock);
      real_v = {pronto, origem, destino, vazio, cheio, n_pendentes, descartado};
      esp_v  = {m_pronto, m_org, m_dst, fila_m.size() == 0, fila_m.size() == PROF,
                NW'(fila_m.size()), m_desc};
      checkOutput("ciclo", {17'b0, real_v}, {17'b0, esp_v});
      if (pronto && !pronto_ant) begin
         entregues.push_back({origem, destino});
         tempos.push_back(k);
      end
      pronto_ant   = pronto;
      cheio_visto  = cheio_visto | cheio;
      pronto_visto = pronto_visto | pronto;
      if (descartado) desc_cont++;
   endtask

   task automatic ocioso(input int n, input logic oc);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 4'd0, oc);
   endtask

   task automatic limpaRegistro();
      entregues.delete();
      tempos.delete();
      cheio_visto  = 1'b0;
      pronto_visto = 1'b0;
      desc_cont    = 0;
   endtask

   initial begin
      tabela[0]  = '{1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, NW'(1)};
      tabela[1]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[2]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[3]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[5]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[6]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, NW'(0)};
      tabela[8]  = '{1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0, NW'(1)};
      tabela[9]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, NW'(0)};
      tabela[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1, NW'(0)};

      // Reset held from time zero; outputs must be in their cleared state.
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_estado", {22'b0, pronto, origem, destino, vazio, cheio, n_pendentes, descartado},
                  {22'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, NW'(0), 1'b0});
      reset = 1'b1;

      $display("[TB] single request table");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(tabela[i].ped, tabela[i].o, tabela[i].d, tabela[i].oc);
         checkOutput("tabela", {18'b0, pronto, origem, destino, vazio, n_pendentes},
                     {18'b0, tabela[i].pr, tabela[i].org, tabela[i].dst, tabela[i].vz, tabela[i].n});
      end
      ocioso(10, 1'b0);

      $display("[TB] burst of four");
      limpaRegistro();
      applyStimulus(1'b1, 4'd1, 4'd5, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'd6, 1'b0);
      applyStimulus(1'b1, 4'd3, 4'd8, 1'b0);
      applyStimulus(1'b1, 4'd9, 4'd0, 1'b0);
      ocioso(36, 1'b0);
      par_esp = '{8'h15, 8'h26, 8'h38, 8'h90};
      checkOutput("burst_qtd", entregues.size(), 4);
      for (int i = 0; i < 4 && i < entregues.size(); i++) begin
         checkOutput("burst_par", {24'b0, entregues[i]}, {24'b0, par_esp[i]});
         if (i > 0) checkOutput("burst_espaco", tempos[i] - tempos[i-1], 8);
      end
      checkOutput("burst_cheio", {31'b0, cheio_visto}, 0);

      $display("[TB] overflow with ocupado held");
      limpaRegistro();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i), 4'(i + 1), 1'b1);
      checkOutput("ovf_n", {29'b0, n_pendentes}, 4);
      checkOutput("ovf_cheio", {31'b0, cheio}, 1);
      checkOutput("ovf_descartado", desc_cont, 1);
      checkOutput("ovf_pronto", {31'b0, pronto_visto}, 0);
      ocioso(40, 1'b0);
      par_esp = '{8'h01, 8'h12, 8'h23, 8'h34};
      checkOutput("ovf_qtd", entregues.size(), 4);
      for (int i = 0; i < 4 && i < entregues.size(); i++) begin
         checkOutput("ovf_par", {24'b0, entregues[i]}, {24'b0, par_esp[i]});
      end

      $display("[TB] ocupado gating");
      limpaRegistro();
      applyStimulus(1'b1, 4'd5, 4'd6, 1'b1);
      ocioso(5, 1'b1);
      checkOutput("gate_pronto", {31'b0, pronto_visto}, 0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
      checkOutput("gate_pulso_inicio", {31'b0, pronto}, 1);
      ocioso(12, 1'b1);
      checkOutput("gate_qtd", entregues.size(), 1);
      ocioso(4, 1'b0);

      $display("[TB] reset during pulse");
      limpaRegistro();
      applyStimulus(1'b1, 4'd6, 4'd7, 1'b0);
      applyStimulus(1'b1, 4'd7, 4'd8, 1'b0);
      applyStimulus(1'b1, 4'd8, 4'd9, 1'b0);
      checkOutput("pre_reset_pronto", {31'b0, pronto}, 1);
      checkOutput("pre_reset_n", {29'b0, n_pendentes}, 2);
      #2 reset = 1'b0;
      #1;
      checkOutput("reset_assinc", {18'b0, pronto, origem, destino, vazio, n_pendentes},
                  {18'b0, 1'b0, 4'd0, 4'd0, 1'b1, NW'(0)});
      fila_m.delete();
      livre    = 0;
      inicio   = -100;
      m_org    = '0;
      m_dst    = '0;
      m_desc   = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      limpaRegistro();
      pronto_ant = 1'b0;
      ocioso(20, 1'b0);
      checkOutput("pos_reset_qtd", entregues.size(), 0);

      $display("[TB] validation");
      limpaRegistro();
      applyStimulus(1'b1, 4'd4, 4'd4, 1'b0);
      ocioso(10, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'd12, 1'b0);
      ocioso(10, 1'b0);
`ifdef EMISSOR_VALIDA_EN
      checkOutput("valida_qtd", entregues.size(), 0);
      checkOutput("valida_descartado", desc_cont, 2);
`else
      checkOutput("valida_qtd", entregues.size(), 2);
      checkOutput("valida_descartado", desc_cont, 0);
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end
      ocioso(60, 1'b0);
      checkOutput("final_vazio", {31'b0, vazio}, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/emissor_pedidos.md
# emissor_pedidos

Request issuer feeding the elevator datapath's request port. Accepts origin/destination call pairs from the cabin/hall panel, buffers them in a small FIFO, and presents them one at a time on `origem`/`destino` with a timed `pronto` level pulse. The pulse is sized for the datapath's `pronto` edge detector and for the controller's two-write enqueue sequence. It is the transmitting end of the `origem`/`destino`/`pronto` interface.

## Interface
- `N_ANDARES`, 16: number of valid floors, 2..16; floors are 0..N_ANDARES-1.
- `PROFUNDIDADE`, 4: FIFO depth in request pairs; power of two, 2..16.
- `T_PRONTO`, 2: cycles `pronto` is held high, ≥1.
- `T_INTERVALO`, 4: cycles `pronto` is held low after each pulse, ≥1; covers the controller's origem/destino RAM writes.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears everything.
- `pedido` in 1: request strobe, sampled each rising edge; one request per high cycle.
- `origem_in` in 4: request origin floor, valid with `pedido`.
- `destino_in` in 4: request destination floor, valid with `pedido`.
- `ocupado` in 1: controller busy; blocks starting a new transfer.
- `origem` out 4: origin presented to the datapath.
- `destino` out 4: destination presented to the datapath.
- `pronto` out 1: transfer strobe level, registered.
- `vazio` out 1: FIFO empty.
- `cheio` out 1: FIFO full.
- `n_pendentes` out $clog2(PROFUNDIDADE+1): FIFO occupancy.
- `descartado` out 1: one-cycle pulse when a request is dropped.

## Operation
- Reset values: `origem`=0, `destino`=0, `pronto`=0, `vazio`=1, `cheio`=0, `n_pendentes`=0, `descartado`=0, FSM=OCIOSO, FIFO pointers 0.
- FIFO push: `pedido`=1 and not dropped → {origem_in, destino_in} written at the tail.
- Drop on push to a full FIFO with no pop in the same cycle. Request lost; `descartado`=1 for one cycle.
- Simultaneous push and pop on a full FIFO is accepted. Occupancy is unchanged.
- Pointers wrap modulo PROFUNDIDADE. Occupancy counter is separate, so full and empty are unambiguous.
- FSM states and transitions:
  - OCIOSO: stays while `vazio`=1 or `ocupado`=1. Otherwise → CARREGA.
  - CARREGA: pops the head into the `origem`/`destino` registers, `pronto`=0, always → PRONTO_ALTO.
  - PRONTO_ALTO: `pronto`=1, counter runs T_PRONTO cycles → INTERVALO.
  - INTERVALO: `pronto`=0, counter runs T_INTERVALO cycles → OCIOSO.
- `ocupado` is sampled only in OCIOSO. Once CARREGA is entered, the transfer completes regardless of `ocupado`.
- `origem`/`destino` are stable from the edge leaving CARREGA until the next CARREGA. They hold their last value while idle.
- The phase counter is width $clog2(max(T_PRONTO,T_INTERVALO)+1) and is reloaded on each state entry.

## Timing
- `pedido` is sampled at edge 0 with the FIFO empty, FSM in OCIOSO and `ocupado`=0:
  - Edge 0: push; `vazio` falls.
  - Edge 1: pop; `origem`/`destino` load.
  - Edge 2: `pronto` rises.
  - Edge 2+T_PRONTO: `pronto` falls.
  - Edge 2+T_PRONTO+T_INTERVALO: FSM back in OCIOSO.
- Back-to-back throughput is one request per T_PRONTO+T_INTERVALO+2 cycles. The defaults give 8.
- Data is set up one full cycle before `pronto` rises and held through the whole INTERVALO phase.
- Reset asserted mid-transfer forces `pronto`=0 immediately (asynchronously). All pending requests are lost.

## Configuration
- `EMISSOR_VALIDA_EN` defined:
  - Pushes are rejected when `origem_in`==`destino_in`, `origem_in`≥N_ANDARES or `destino_in`≥N_ANDARES.
  - A rejected request is not stored and pulses `descartado` for one cycle, same timing as overflow.
- `EMISSOR_VALIDA_EN` undefined: every request is stored, subject only to the overflow rule.

## Structure
- Package `emissor_pkg` holds:
  - the state enum (OCIOSO, CARREGA, PRONTO_ALTO, INTERVALO);
  - the default parameter constants;
  - the packed pair typedef {origem[3:0], destino[3:0]}.
- One sub-module, `fila_pedidos`: a synchronous FIFO of pair entries with push, pop, occupancy, full and empty. It has no drop logic, which belongs to the top.

## Test plan
- Single request: `pedido` with 3→7 at edge 0 → `origem`=3, `destino`=7 after edge 1; `pronto` high from edge 2 to edge 4; OCIOSO at edge 8.
- Burst: 4 pedidos on consecutive cycles (1→5, 2→6, 3→8, 9→0) → four `pronto` pulses, 8 cycles apart, in order; `cheio`=0 throughout with depth 4.
- Overflow: hold `ocupado`=1 and push 5 requests → `n_pendentes`=4, `cheio`=1, one `descartado` pulse on the 5th. Release `ocupado` → first four delivered in order.
- `ocupado` gating: `ocupado`=1 with a pending request → `pronto` stays 0. Raising `ocupado` during PRONTO_ALTO does not shorten or abort the pulse.
- Reset mid-pulse: assert `reset` while `pronto`=1 with 2 queued → `pronto`=0 without waiting for an edge, `vazio`=1, outputs 0, and no pulse after release.
- Validation: with `EMISSOR_VALIDA_EN`, requests 4→4 and 2→12 at N_ANDARES=10 → each pulses `descartado` and nothing is sent. Without the macro, both are delivered.
